// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX scheduler slice.
package uart_sched_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_LOCK = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_START = 2'd1,
    D_WAIT  = 2'd2
  } drn_state_t;
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester, FIFO and UART TX signals of the scheduler; master is the scheduler side.
// Handshake: a byte moves on a cycle where req_valid[i] and req_ready[i] are both high; valid may not wait for ready.
interface uart_tx_scheduler_if #(
  parameter int NREQ = 2
);
  import uart_sched_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*BYTE_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic [BYTE_W-1:0]      fifo_wData;
  logic                   fifo_wr;
  logic                   fifo_full;
  logic [BYTE_W-1:0]      fifo_rData;
  logic                   fifo_empty;
  logic                   fifo_rd;
  logic                   tx_start;
  logic [BYTE_W-1:0]      tx_data;
  logic                   tx_busy;
  logic                   tx_done;
  logic                   grant_id;
  logic                   locked;
  logic                   err_timeout;
  arb_state_t             arb_state;
  drn_state_t             drn_state;

  modport master (
    input  req_valid, req_data, req_last, fifo_full, fifo_rData, fifo_empty, tx_busy, tx_done,
    output req_ready, fifo_wData, fifo_wr, fifo_rd, tx_start, tx_data,
    output grant_id, locked, err_timeout, arb_state, drn_state
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_full, fifo_rData, fifo_empty, tx_busy, tx_done,
    input  req_ready, fifo_wData, fifo_wr, fifo_rd, tx_start, tx_data,
    input  grant_id, locked, err_timeout, arb_state, drn_state
  );
endinterface

// File: rtl/tx_drain_ctrl.sv
// FIFO read-side sequencer: pops one byte when the UART is free, pulses tx_start, waits for tx_done.
module tx_drain_ctrl
  import uart_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty_i,
  input  logic [BYTE_W-1:0] fifo_rData_i,
  input  logic              tx_busy_i,
  input  logic              tx_done_i,
  output logic              fifo_rd_o,
  output logic              tx_start_o,
  output logic [BYTE_W-1:0] tx_data_o,
  output drn_state_t        state_o
);
  drn_state_t        state_q;
  logic              start_q;
  logic [BYTE_W-1:0] data_q;

  // The pop is combinational so the head byte is captured on the same edge it leaves the FIFO.
  assign fifo_rd_o  = (state_q == D_IDLE) & ~fifo_empty_i & ~tx_busy_i;
  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;
  assign state_o    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= D_IDLE;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        D_IDLE: begin
          if (fifo_rd_o) begin
            data_q  <= fifo_rData_i;
            start_q <= 1'b1;
            state_q <= D_START;
          end
        end
        D_START: state_q <= D_WAIT;
        D_WAIT: begin
          if (tx_done_i) state_q <= D_IDLE;
        end
        default: state_q <= D_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-locked round-robin arbiter for the TX FIFO write port, plus the FIFO-to-UART drain.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 10
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_scheduler_if.master bus
);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  arb_state_t        arb_q;
  logic              owner_q;
  logic              last_q;
  logic              err_q;
  logic [TW-1:0]     tmo_q;

  logic              pick;
  logic              own_valid;
  logic              own_last;
  logic              xfer;
  logic [BYTE_W-1:0] own_data;
  logic [NREQ-1:0]   ready_vec;
  drn_state_t        drn_state;

  always_comb begin
    own_valid = owner_q ? bus.req_valid[1] : bus.req_valid[0];
    own_last  = owner_q ? bus.req_last[1]  : bus.req_last[0];
    own_data  = owner_q ? bus.req_data[2*BYTE_W-1:BYTE_W] : bus.req_data[BYTE_W-1:0];
    // On contention the requester that did not own the previous packet wins.
    pick      = (bus.req_valid[0] & bus.req_valid[1]) ? ~last_q : bus.req_valid[1];
    ready_vec = '0;
    if (arb_q == A_LOCK) ready_vec[owner_q] = ~bus.fifo_full;
    xfer      = (arb_q == A_LOCK) & own_valid & ~bus.fifo_full;
  end

  assign bus.req_ready   = ready_vec;
  assign bus.fifo_wr     = xfer;
  assign bus.fifo_wData  = (arb_q == A_LOCK) ? own_data : '0;
  assign bus.grant_id    = owner_q;
  assign bus.locked      = (arb_q == A_LOCK);
  assign bus.err_timeout = err_q;
  assign bus.arb_state   = arb_q;
  assign bus.drn_state   = drn_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_q   <= A_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (arb_q)
        A_IDLE: begin
          tmo_q <= '0;
          if (|bus.req_valid) begin
            arb_q   <= A_LOCK;
            owner_q <= pick;
          end
        end
        A_LOCK: begin
          if (xfer) begin
            tmo_q <= '0;
            if (own_last) begin
              arb_q  <= A_IDLE;
              last_q <= owner_q;
            end
          end else if (tmo_q == TMO_LAST) begin
            // Owner went silent mid-packet: drop the lock so the other side is not starved.
            arb_q  <= A_IDLE;
            last_q <= owner_q;
            err_q  <= 1'b1;
            tmo_q  <= '0;
          end else if (!own_valid) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: arb_q <= A_IDLE;
      endcase
    end
  end

  tx_drain_ctrl u_drain (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (bus.fifo_empty),
    .fifo_rData_i (bus.fifo_rData),
    .tx_busy_i    (bus.tx_busy),
    .tx_done_i    (bus.tx_done),
    .fifo_rd_o    (bus.fifo_rd),
    .tx_start_o   (bus.tx_start),
    .tx_data_o    (bus.tx_data),
    .state_o      (drn_state)
  );
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with an 8-deep FIFO model and a fixed-latency UART model.
module tb_uart_tx_scheduler;
  import uart_sched_pkg::*;

  localparam int NREQ     = 2;
  localparam int TIMEOUT  = 1024;
  localparam int TW       = 10;
  localparam int UART_LAT = 12;
  localparam int BUDGET   = 2000;

  logic clk = 1'b0;
  logic rst;
  logic hold_busy;
  logic uart_busy;
  logic done_n;
  int   uart_cnt;

  uart_tx_scheduler_if #(.NREQ(NREQ)) bus ();

  uart_tx_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] exp_q[$];
  logic [7:0] push_log[$];
  logic [7:0] tx_log[$];
  logic [7:0] fifo_q[$];
  int rd_cnt, rd_empty_n, start_cnt, err_cnt, lat_err, stall_cyc, stall_err, glitch_n, overflow_n;
  logic rd_prev;
  int t4_cyc;
  int wait_cnt;

  logic [7:0] pkt [2][16];
  int         pkt_len [2];
  logic       no_last [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  assign bus.tx_busy = uart_busy | hold_busy;

  // FIFO + UART environment; outputs change only via NBA so the DUT sees pre-edge values.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q = {};
      uart_cnt = 0;
      rd_prev = 1'b0;
      bus.fifo_empty <= 1'b1;
      bus.fifo_full  <= 1'b0;
      bus.fifo_rData <= 8'h00;
      bus.tx_done    <= 1'b0;
      uart_busy      <= 1'b0;
    end else begin
      if (bus.fifo_rd) begin
        rd_cnt++;
        if (fifo_q.size() == 0) rd_empty_n++;
        else void'(fifo_q.pop_front());
      end
      if (bus.fifo_wr) begin
        push_log.push_back(bus.fifo_wData);
        if (fifo_q.size() < 8) fifo_q.push_back(bus.fifo_wData);
        else overflow_n++;
      end
      if (bus.tx_start) begin
        tx_log.push_back(bus.tx_data);
        start_cnt++;
      end
      if (bus.tx_start !== rd_prev) lat_err++;
      rd_prev = bus.fifo_rd;
      if (bus.err_timeout) err_cnt++;
      if (bus.locked && bus.req_valid[bus.grant_id] && bus.fifo_full) begin
        stall_cyc++;
        if (bus.req_ready[bus.grant_id]) stall_err++;
      end
      done_n = 1'b0;
      if (bus.tx_start) uart_cnt = UART_LAT - 1;
      else if (uart_cnt > 0) begin
        uart_cnt--;
        done_n = (uart_cnt == 0);
      end
      bus.tx_done    <= done_n;
      uart_busy      <= (uart_cnt > 0);
      bus.fifo_empty <= (fifo_q.size() == 0);
      bus.fifo_full  <= (fifo_q.size() == 8);
      bus.fifo_rData <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  always @(negedge clk) if (rst && bus.tx_start) glitch_n++;

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    exp_q = {};
    push_log = {};
    tx_log = {};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  task automatic send_pkt(input int id);
    int budget;
    for (int i = 0; i < pkt_len[id]; i++) begin
      bus.req_valid[id] = 1'b1;
      bus.req_data[id*8 +: 8] = pkt[id][i];
      bus.req_last[id] = (i == pkt_len[id] - 1) && !no_last[id];
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!bus.req_ready[id] && budget < BUDGET);
      if (!bus.req_ready[id]) begin
        check($sformatf("req%0d_ready_wait", id), 32'(bus.req_ready[id]), 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid[id] = 1'b0;
    bus.req_last[id]  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    logic idle;
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      idle = bus.fifo_empty && (bus.drn_state == D_IDLE) && !bus.tx_busy && !bus.locked;
    end while (!idle && cnt < BUDGET);
    check({tag, "_idle"}, 32'(idle), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag, input logic [7:0] lg[$]);
    check({tag, "_n"}, lg.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < lg.size()) ? 32'(lg[i]) : 32'hdead, 32'(exp_q[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    hold_busy = 1'b0;
    no_last[0] = 1'b0;
    no_last[1] = 1'b0;
    rd_cnt = 0; rd_empty_n = 0; start_cnt = 0; err_cnt = 0; lat_err = 0;
    stall_cyc = 0; stall_err = 0; glitch_n = 0; overflow_n = 0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_outputs", {bus.req_ready, bus.fifo_wData, bus.fifo_wr, bus.fifo_rd, bus.tx_start,
                          bus.tx_data, bus.grant_id, bus.locked, bus.err_timeout}, 0);
    check("rst_arb_state", 32'(bus.arb_state), 32'(A_IDLE));
    check("rst_drn_state", 32'(bus.drn_state), 32'(D_IDLE));
    @(posedge clk); #1;

    // 1: requester 0 alone, three bytes
    pkt[0][0] = 8'h41; pkt[0][1] = 8'h42; pkt[0][2] = 8'h43; pkt_len[0] = 3;
    exp_q = '{8'h41, 8'h42, 8'h43};
    send_pkt(0);
    @(negedge clk);
    check("t1_locked_after_last", 32'(bus.locked), 0);
    check("t1_grant", 32'(bus.grant_id), 0);
    check_log("t1_push", push_log);
    wait_drain("t1");
    check_log("t1_tx", tx_log);

    // 2: contention after reset, then pointer flip
    do_reset();
    pkt[0][0] = 8'h10; pkt[0][1] = 8'h11; pkt_len[0] = 2;
    pkt[1][0] = 8'h20; pkt_len[1] = 1;
    fork
      send_pkt(0);
      send_pkt(1);
    join
    pkt[0][0] = 8'h12; pkt_len[0] = 1;
    send_pkt(0);
    pkt[0][0] = 8'h10; pkt[0][1] = 8'h11; pkt_len[0] = 2;
    fork
      send_pkt(0);
      send_pkt(1);
    join
    @(negedge clk);
    check("t2_grant_last", 32'(bus.grant_id), 0);
    exp_q = '{8'h10, 8'h11, 8'h20, 8'h12, 8'h20, 8'h10, 8'h11};
    check_log("t2_push", push_log);
    wait_drain("t2");
    check_log("t2_tx", tx_log);

    // 3: ten bytes from requester 1 into a full FIFO
    clear_logs();
    hold_busy = 1'b1;
    for (int i = 0; i < 10; i++) pkt[1][i] = 8'h30 + 8'(i);
    pkt_len[1] = 10;
    fork
      send_pkt(1);
      begin
        wait_cnt = 0;
        do begin
          @(negedge clk);
          wait_cnt++;
        end while (!bus.fifo_full && wait_cnt < BUDGET);
        check("t3_full_seen", 32'(bus.fifo_full), 1);
        check("t3_pushed_at_full", push_log.size(), 8);
        repeat (4) @(negedge clk);
        check("t3_ready1_stalled", 32'(bus.req_ready[1]), 0);
        check("t3_no_push_while_full", push_log.size(), 8);
        hold_busy = 1'b0;
      end
    join
    for (int i = 0; i < 10; i++) exp_q.push_back(8'h30 + 8'(i));
    wait_drain("t3");
    check_log("t3_push", push_log);
    check_log("t3_tx", tx_log);
    check("t3_stall_cycles_seen", 32'(stall_cyc > 0), 1);
    check("t3_ready_during_full", stall_err, 0);
    check("t3_fifo_overflow", overflow_n, 0);

    // 4: owner stalls mid-packet, lock released by timeout
    clear_logs();
    err_cnt = 0;
    pkt[0][0] = 8'h77; pkt_len[0] = 1; no_last[0] = 1'b1;
    send_pkt(0);
    no_last[0] = 1'b0;
    pkt[1][0] = 8'h88; pkt_len[1] = 1;
    fork
      send_pkt(1);
      begin
        t4_cyc = 0;
        do begin
          @(negedge clk);
          t4_cyc++;
        end while (!bus.err_timeout && t4_cyc < 3000);
        check("t4_release_cycle", t4_cyc, TIMEOUT + 1);
        check("t4_locked_at_err", 32'(bus.locked), 0);
        check("t4_grant_at_err", 32'(bus.grant_id), 0);
        @(negedge clk);
        check("t4_err_one_cycle", 32'(bus.err_timeout), 0);
        check("t4_regrant_locked", 32'(bus.locked), 1);
        check("t4_regrant_id", 32'(bus.grant_id), 1);
      end
    join
    exp_q = '{8'h77, 8'h88};
    wait_drain("t4");
    check("t4_err_count", err_cnt, 1);
    check_log("t4_push", push_log);

    // 5: two bytes drained with 12-cycle UART
    clear_logs();
    rd_cnt = 0; rd_empty_n = 0; start_cnt = 0;
    pkt[0][0] = 8'h55; pkt[0][1] = 8'hAA; pkt_len[0] = 2;
    send_pkt(0);
    exp_q = '{8'h55, 8'hAA};
    wait_drain("t5");
    check_log("t5_tx", tx_log);
    check("t5_start_count", start_cnt, 2);
    check("t5_rd_count", rd_cnt, 2);
    check("t5_rd_while_empty", rd_empty_n, 0);
    check("t5_tx_data_hold", 32'(bus.tx_data), 32'h0AA);

    // 6: reset mid-packet with the drain waiting on the UART
    clear_logs();
    bus.req_valid[0] = 1'b1; bus.req_data[7:0] = 8'hA1; bus.req_last[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_cnt = 0;
      do begin
        @(negedge clk);
        wait_cnt++;
      end while (!bus.req_ready[0] && wait_cnt < BUDGET);
      @(posedge clk); #1;
      bus.req_data[7:0] = 8'hA2;
    end
    bus.req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_pre_pushed", push_log.size(), 2);
    check("t6_pre_drn_wait", 32'(bus.drn_state), 32'(D_WAIT));
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid[0] = 1'b1; bus.req_data[7:0] = 8'hA3;
    @(negedge clk);
    check("t6_rst_outputs", {bus.req_ready, bus.fifo_wData, bus.fifo_wr, bus.fifo_rd, bus.tx_start,
                             bus.tx_data, bus.grant_id, bus.locked, bus.err_timeout}, 0);
    check("t6_rst_drn_state", 32'(bus.drn_state), 32'(D_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid[0] = 1'b0;
    clear_logs();
    pkt[1][0] = 8'h61; pkt[1][1] = 8'h62; pkt_len[1] = 2;
    send_pkt(1);
    @(negedge clk);
    check("t6_grant_after_rst", 32'(bus.grant_id), 1);
    exp_q = '{8'h61, 8'h62};
    check_log("t6_push", push_log);
    wait_drain("t6");
    check_log("t6_tx", tx_log);
    check("t6_start_glitch", glitch_n, 0);
    check("pop_to_start_latency", lat_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
